nco_phase_gen: RTL and testbench
================================

// Module: nco_phase_gen
// PURPOSE
//  Phase-accumulator NCO with a linear-chirp sweep engine. Generates the unsigned phase word
//  that feeds the sincos stage directly (o_phase -> sincos.a, 0..2^NBA-1 = 0..360 deg).
//  Frequency, chirp rate, sweep length and phase offset load through a valid/ready port.
//  Updates are double-buffered, so frequency changes are phase-continuous.
// PARAMETERS
//  NBA  26  output phase width; must equal the sincos NBA
//  NBF  32  accumulator / frequency-word width (NBF >= NBA)
//  NBS  24  sweep step counter width
// PORTS
//  c           in   1    clock, all logic on posedge
//  r           in   1    synchronous reset, active high
//  cfg_valid   in   1    config word valid
//  cfg_ready   out  1    shadow register free; transfer on cfg_valid & cfg_ready
//  cfg_freq    in   NBF  start frequency word (phase step per clock, unsigned, modular)
//  cfg_rate    in   NBF  chirp rate, signed, added to freq every sweep clock
//  cfg_len     in   NBS  sweep length in clocks
//  cfg_offset  in   NBA  phase offset added after truncation
//  start       in   1    pulse: begin RUN/SWEEP
//  stop        in   1    pulse: return to IDLE, accumulator held
//  sync        in   1    pulse: zero accumulator
//  busy        out  1    state == SWEEP
//  o_phase     out  NBA  acc[NBF-1 -: NBA] + offset (mod 2^NBA), registered
//  o_valid     out  1    state != IDLE, aligned with o_phase
// BEHAVIOUR
//  Reset: state=IDLE; acc, freq, rate, len, offset, count = 0; pending=0; cfg_ready=1;
//   busy=0; o_phase=0; o_valid=0. A reset mid-sweep aborts in one clock. No residual state.
//  Config: transfer -> shadow regs, pending=1, cfg_ready=!pending (registered).
//   Commit, shadow -> active: in IDLE or RUN, the clock after the transfer.
//   In SWEEP, commit is deferred to the first RUN clock after the sweep ends.
//   On commit, pending=0. Commit never touches acc (phase-continuous).
//  States: IDLE, RUN, SWEEP.
//   IDLE:  acc held. start -> SWEEP if rate!=0 && len!=0, else -> RUN.
//   RUN:   acc += freq each clock. start with rate!=0 && len!=0 -> SWEEP.
//   SWEEP: acc += freq; freq += rate (modular); count++.
//          When count==len-1: -> RUN, count=0, final freq retained. start ignored.
//  stop: any state -> IDLE. stop beats start when both are asserted.
//  sync: acc <= 0 in place of the increment, in any state.
//   sync + commit or sync + stop in the same clock: both take effect.
//  Latency: one clock from acc update to o_phase/o_valid. o_phase keeps tracking offset in IDLE.
//  Wrap: acc, freq and o_phase are all modulo their widths. No saturation, no flags.
// CONFIGURATION
//  NCO_DITHER_EN defined:
//   A 32-bit maximal LFSR (x^32+x^22+x^2+x+1, seed 1 on reset) supplies NBF-NBA LSBs.
//   These are added to acc before truncation to o_phase. Spur reduction only; acc is unchanged.
//  NCO_DITHER_EN undefined: plain truncation, no LFSR logic. This is bit-exact with the test vectors.
// STRUCTURE
//  Shared package nco_pkg: state encoding (IDLE=0, RUN=1, SWEEP=2), default NBA/NBF/NBS,
//   LFSR taps and seed constant.
//  One sub-module, nco_lfsr: the dither generator, instantiated only under NCO_DITHER_EN.
//  Everything else (FSM, shadow regs, accumulator, output reg) lives in nco_phase_gen.
// TESTING  (NBF=32, NBA=26, dither off)
//  1. Reset, cfg freq=2^28 rate=0 offset=0, start
//     -> o_phase steps 2^22 per clock; wraps to 0 every 16 clocks; o_valid=1.
//  2. RUN at freq=2^28; load freq=2^27 mid-run
//     -> step changes to 2^21 two clocks after the transfer, with no phase jump.
//     cfg_ready is low for exactly one clock.
//  3. freq=0, rate=2^20, len=8, start
//     -> busy high 8 clocks; o_phase increments 0,1,2..7 x 2^14.
//     Then RUN holds freq=2^23; busy=0.
//  4. Config sent during SWEEP
//     -> cfg_ready stays low and freq keeps ramping until the sweep ends.
//     Commit happens on the first RUN clock.
//  5. start+stop together; sync during RUN; r asserted mid-sweep
//     -> IDLE; acc=0 next clock; all outputs at reset values one clock later.
//  6. offset=2^25 with acc=0 in IDLE
//     -> o_phase=2^25, o_valid=0.
//     Define NCO_DITHER_EN -> o_phase differs from case 1 by at most 1 LSB.

Source files
------------

// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared state encoding, default widths and dither LFSR constants for the NCO
package nco_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWEEP = 2'd2
    } nco_state_e;

    localparam int NCO_NBA = 26;
    localparam int NCO_NBF = 32;
    localparam int NCO_NBS = 24;

    // x^32 + x^22 + x^2 + x + 1; feedback is the parity of the tapped bits
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

endpackage

// File: rtl/nco_lfsr.sv
// rtl/nco_lfsr.sv - 32-bit maximal-length LFSR used as the phase dither source
module nco_lfsr
    import nco_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] lfsr_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[30:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/nco_phase_gen.sv
// rtl/nco_phase_gen.sv - phase-accumulator NCO with double-buffered config and linear-chirp sweep
// Optional: NCO_DITHER_EN adds LFSR dither below the truncation point of the output phase.
module nco_phase_gen
    import nco_pkg::*;
#(
    parameter int NBA = NCO_NBA,
    parameter int NBF = NCO_NBF,
    parameter int NBS = NCO_NBS
) (
    input  logic           c,
    input  logic           r,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [NBF-1:0] cfg_freq,
    input  logic [NBF-1:0] cfg_rate,
    input  logic [NBS-1:0] cfg_len,
    input  logic [NBA-1:0] cfg_offset,
    input  logic           start,
    input  logic           stop,
    input  logic           sync,
    output logic           busy,
    output logic [NBA-1:0] o_phase,
    output logic           o_valid
);

    nco_state_e     state_q, state_d;
    logic [NBF-1:0] acc_q, acc_d;
    logic [NBF-1:0] freq_q, freq_d;
    logic [NBF-1:0] rate_q, rate_d;
    logic [NBS-1:0] len_q, len_d;
    logic [NBA-1:0] offset_q, offset_d;
    logic [NBS-1:0] count_q, count_d;
    logic [NBF-1:0] sh_freq_q, sh_freq_d;
    logic [NBF-1:0] sh_rate_q, sh_rate_d;
    logic [NBS-1:0] sh_len_q, sh_len_d;
    logic [NBA-1:0] sh_offset_q, sh_offset_d;
    logic           pending_q, pending_d;
    logic           cfg_ready_q, cfg_ready_d;
    logic [NBA-1:0] o_phase_q, o_phase_d;
    logic           o_valid_q, o_valid_d;

    logic           transfer;
    logic           commit;
    logic           sweep_ok;
    logic [NBA-1:0] phase_trunc;

`ifdef NCO_DITHER_EN
    localparam logic [NBF-1:0] DITHER_MASK = (NBF'(1) << (NBF - NBA)) - NBF'(1);
    logic [31:0]    lfsr;
    logic [NBF-1:0] dithered;

    nco_lfsr u_lfsr (
        .clk_i  (c),
        .rst_i  (r),
        .lfsr_o (lfsr)
    );

    assign dithered    = acc_q + (NBF'(lfsr) & DITHER_MASK);
    assign phase_trunc = dithered[NBF-1 -: NBA];
`else
    assign phase_trunc = acc_q[NBF-1 -: NBA];
`endif

    always_comb begin
        transfer = cfg_valid & cfg_ready_q;
        // A sweep owns freq; new settings wait until it has handed back to RUN
        commit   = pending_q & (state_q != ST_SWEEP);

        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        freq_d      = commit ? sh_freq_q   : freq_q;
        rate_d      = commit ? sh_rate_q   : rate_q;
        len_d       = commit ? sh_len_q    : len_q;
        offset_d    = commit ? sh_offset_q : offset_q;
        sh_freq_d   = transfer ? cfg_freq   : sh_freq_q;
        sh_rate_d   = transfer ? cfg_rate   : sh_rate_q;
        sh_len_d    = transfer ? cfg_len    : sh_len_q;
        sh_offset_d = transfer ? cfg_offset : sh_offset_q;
        sweep_ok    = (rate_d != '0) && (len_d != '0);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = sweep_ok ? ST_SWEEP : ST_RUN;
                    count_d = '0;
                end
            end
            ST_RUN: begin
                acc_d = acc_q + freq_q;
                if (start && sweep_ok) begin
                    state_d = ST_SWEEP;
                    count_d = '0;
                end
            end
            ST_SWEEP: begin
                acc_d  = acc_q + freq_q;
                freq_d = freq_q + rate_q;
                if (count_q == len_q - NBS'(1)) begin
                    state_d = ST_RUN;
                    count_d = '0;
                end else begin
                    count_d = count_q + NBS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stop) begin
            state_d = ST_IDLE;
            acc_d   = acc_q;
            freq_d  = commit ? sh_freq_q : freq_q;
            count_d = '0;
        end
        if (sync) begin
            acc_d = '0;
        end

        pending_d = pending_q;
        if (commit) begin
            pending_d = 1'b0;
        end
        if (transfer) begin
            pending_d = 1'b1;
        end
        cfg_ready_d = ~pending_d;

        o_phase_d = phase_trunc + offset_q;
        o_valid_d = (state_q != ST_IDLE);
    end

    always_ff @(posedge c) begin
        if (r) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            freq_q      <= '0;
            rate_q      <= '0;
            len_q       <= '0;
            offset_q    <= '0;
            count_q     <= '0;
            sh_freq_q   <= '0;
            sh_rate_q   <= '0;
            sh_len_q    <= '0;
            sh_offset_q <= '0;
            pending_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            o_phase_q   <= '0;
            o_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            freq_q      <= freq_d;
            rate_q      <= rate_d;
            len_q       <= len_d;
            offset_q    <= offset_d;
            count_q     <= count_d;
            sh_freq_q   <= sh_freq_d;
            sh_rate_q   <= sh_rate_d;
            sh_len_q    <= sh_len_d;
            sh_offset_q <= sh_offset_d;
            pending_q   <= pending_d;
            cfg_ready_q <= cfg_ready_d;
            o_phase_q   <= o_phase_d;
            o_valid_q   <= o_valid_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = (state_q == ST_SWEEP);
    assign o_phase   = o_phase_q;
    assign o_valid   = o_valid_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// tb/tb_nco_phase_gen.sv - self-checking bench for nco_phase_gen: vector table, corner sequences, random vs model
module tb_nco_phase_gen;

    logic        c = 1'b0;
    logic        r = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_freq = '0;
    logic [31:0] cfg_rate = '0;
    logic [23:0] cfg_len = '0;
    logic [25:0] cfg_offset = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        sync = 1'b0;
    logic        busy;
    logic [25:0] o_phase;
    logic        o_valid;

    int n_cmp = 0;
    int n_fail = 0;

    nco_phase_gen #(.NBA(26), .NBF(32), .NBS(24)) dut (
        .c          (c),
        .r          (r),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_freq   (cfg_freq),
        .cfg_rate   (cfg_rate),
        .cfg_len    (cfg_len),
        .cfg_offset (cfg_offset),
        .start      (start),
        .stop       (stop),
        .sync       (sync),
        .busy       (busy),
        .o_phase    (o_phase),
        .o_valid    (o_valid)
    );

    always #5 c = ~c;

    // Reference model: operating mode plus the visible registers, advanced once per clock
    localparam int M_IDLE = 0;
    localparam int M_RUN = 1;
    localparam int M_SWEEP = 2;
    int          m_mode = M_IDLE;
    logic [31:0] m_acc, m_freq, m_rate, s_freq, s_rate;
    logic [23:0] m_len, s_len, m_left;
    logic [25:0] m_off, s_off, m_phase;
    bit          m_pend, m_rdy, m_valid;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [25:0] nphase;
        logic [31:0] step_f;
        bit          nvalid, take, commit;
        if (r) begin
            m_mode = M_IDLE;
            m_acc = 0; m_freq = 0; m_rate = 0; m_len = 0; m_off = 0; m_left = 0;
            s_freq = 0; s_rate = 0; s_len = 0; s_off = 0;
            m_pend = 0; m_rdy = 1; m_phase = 0; m_valid = 0;
            return;
        end
        nphase = 26'(m_acc >> 6) + m_off;
        nvalid = (m_mode != M_IDLE);
        take   = cfg_valid && m_rdy;
        commit = m_pend && (m_mode != M_SWEEP);
        step_f = m_freq;
        if (commit) begin
            m_freq = s_freq; m_rate = s_rate; m_len = s_len; m_off = s_off;
            m_pend = 0;
        end
        if (stop) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (start) begin
                m_mode = (m_rate != 0 && m_len != 0) ? M_SWEEP : M_RUN;
                m_left = m_len;
            end
        end else if (m_mode == M_RUN) begin
            m_acc = m_acc + step_f;
            if (start && m_rate != 0 && m_len != 0) begin
                m_mode = M_SWEEP;
                m_left = m_len;
            end
        end else begin
            m_acc  = m_acc + step_f;
            m_freq = step_f + m_rate;
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_RUN;
        end
        if (sync) m_acc = 0;
        if (take) begin
            s_freq = cfg_freq; s_rate = cfg_rate; s_len = cfg_len; s_off = cfg_offset;
            m_pend = 1;
        end
        m_rdy   = !m_pend;
        m_phase = nphase;
        m_valid = nvalid;
    endtask

    task automatic step();
        @(posedge c);
        model_update();
        #1;
        check("model o_phase", o_phase, m_phase);
        check("model o_valid", o_valid, m_valid);
        check("model busy", busy, m_mode == M_SWEEP);
        check("model cfg_ready", cfg_ready, m_rdy);
        cfg_valid = 0; start = 0; stop = 0; sync = 0; r = 0;
    endtask

    typedef struct {
        bit          cv;
        bit          st;
        logic [31:0] f;
        logic [25:0] ph;
        bit          v;
        bit          b;
        bit          rdy;
    } vec_t;

    function automatic vec_t mkv(bit cv, bit st, logic [31:0] f, logic [25:0] ph, bit v, bit b, bit rdy);
        vec_t x;
        x.cv = cv; x.st = st; x.f = f; x.ph = ph; x.v = v; x.b = b; x.rdy = rdy;
        return x;
    endfunction

    vec_t        tbl[21];
    logic [25:0] ph[13];
    bit          bz[13];
    logic [25:0] d;
    int          cnt;

    initial begin
        // Case 1 table: load freq=2^28, start, then 2^22 steps wrapping every 16 clocks
        tbl[0] = mkv(1, 0, 32'h1000_0000, 26'd0, 0, 0, 0);
        tbl[1] = mkv(0, 0, 32'h0, 26'd0, 0, 0, 1);
        tbl[2] = mkv(0, 1, 32'h0, 26'd0, 0, 0, 1);
        for (int k = 3; k < 21; k++) begin
            tbl[k] = mkv(0, 0, 32'h0, 26'((k - 3) << 22), 1, 0, 1);
        end

        r = 1; step();
        r = 1; step();
        check("reset o_phase", o_phase, 0);
        check("reset o_valid", o_valid, 0);
        check("reset busy", busy, 0);
        check("reset cfg_ready", cfg_ready, 1);

        for (int k = 0; k < 21; k++) begin
            cfg_valid = tbl[k].cv; cfg_freq = tbl[k].f;
            cfg_rate = 0; cfg_len = 0; cfg_offset = 0;
            start = tbl[k].st;
            step();
            check($sformatf("vec%0d o_phase", k), o_phase, tbl[k].ph);
            check($sformatf("vec%0d o_valid", k), o_valid, tbl[k].v);
            check($sformatf("vec%0d busy", k), busy, tbl[k].b);
            check($sformatf("vec%0d cfg_ready", k), cfg_ready, tbl[k].rdy);
        end

        // Case 2: mid-run frequency change is phase-continuous; ready low one clock
        cfg_valid = 1; cfg_freq = 32'h0800_0000;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            ph[i] = o_phase;
            if (!cfg_ready) cnt++;
        end
        check("retune ready low clocks", cnt, 1);
        for (int i = 1; i < 5; i++) begin
            d = ph[i] - ph[i-1];
            check($sformatf("retune step%0d", i), d, (i < 3) ? 64'h40_0000 : 64'h20_0000);
        end

        // Case 3: chirp from 0 at 2^20 per clock for 8 clocks
        stop = 1; sync = 1; cfg_valid = 1;
        cfg_freq = 0; cfg_rate = 32'h0010_0000; cfg_len = 8; cfg_offset = 0;
        step();
        step();
        start = 1;
        for (int i = 0; i < 13; i++) begin
            step();
            ph[i] = o_phase;
            bz[i] = busy;
        end
        cnt = 0;
        for (int i = 0; i < 13; i++) if (bz[i]) cnt++;
        check("sweep busy clocks", cnt, 8);
        check("sweep busy last", bz[7], 1);
        check("sweep busy done", bz[8], 0);
        for (int i = 2; i < 13; i++) begin
            d = ph[i] - ph[i-1];
            check($sformatf("sweep step%0d", i), d, (i < 10) ? 64'(i - 2) << 14 : 64'h2_0000);
        end

        // Case 4: config sent during a sweep waits for the first RUN clock
        start = 1; step();
        cfg_valid = 1; cfg_freq = 32'h0040_0000; cfg_rate = 0; cfg_len = 0;
        step();
        cnt = cfg_ready ? 0 : 1;
        for (int i = 0; i < 11; i++) begin
            step();
            ph[i] = o_phase;
            if (!cfg_ready) cnt++;
        end
        check("deferred ready low clocks", cnt, 8);
        d = ph[8] - ph[7];
        check("deferred final ramp step", d, 64'h4_0000);
        d = ph[9] - ph[8];
        check("deferred committed step", d, 64'h1_0000);

        // Case 5: start+stop, sync in RUN, reset mid-sweep
        start = 1; stop = 1; step();
        check("start+stop busy", busy, 0);
        step();
        check("start+stop o_valid", o_valid, 0);
        start = 1; step();
        step(); step();
        sync = 1; step();
        step();
        check("sync o_phase", o_phase, 0);
        cfg_valid = 1; cfg_freq = 0; cfg_rate = 32'h0010_0000; cfg_len = 8;
        step(); step();
        start = 1; step();
        step(); step();
        check("pre-reset busy", busy, 1);
        r = 1; step();
        check("abort o_phase", o_phase, 0);
        check("abort o_valid", o_valid, 0);
        check("abort busy", busy, 0);
        check("abort cfg_ready", cfg_ready, 1);
        step();
        check("post-abort o_phase", o_phase, 0);

        // Case 6: offset shows through in IDLE with acc=0
        cfg_valid = 1; cfg_freq = 0; cfg_rate = 0; cfg_len = 0; cfg_offset = 26'h200_0000;
        step(); step(); step();
        check("idle offset o_phase", o_phase, 64'h200_0000);
        check("idle offset o_valid", o_valid, 0);

        // Randomised traffic against the model
        r = 1; step();
        for (int i = 0; i < 4000; i++) begin
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_freq   = $urandom;
            cfg_rate   = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            cfg_len    = 24'($urandom_range(0, 12));
            cfg_offset = 26'($urandom);
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            sync       = ($urandom_range(0, 39) == 0);
            r          = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
